iddmm_seq: RTL
==============

# iddmm_seq

Job sequencer for the `iddmm_top` Montgomery multiplier. It accepts one operand stream per job (m1, x, y, m words) and writes it into the multiplier's operand RAMs. It then runs the request/grant handshake, captures the N result words into a local buffer, and streams them out with backpressure. It sits between the Paillier top-level control and one `iddmm_top` instance.

## Interface
- `K`, 128, bits per word
- `N`, 32, words per operand
- `ADDR_W`, `$clog2(N)`, word address width
---
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  job start pulse, honoured only in IDLE
- `keep_m`  in  1  sampled with `start`; skip m1/m reload (only with macro)
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  sticky protocol error, cleared by accepted `start`
- `done`  out  1  one-cycle pulse after last output handshake
- `in_valid` / `in_ready`  in / out  1  operand stream handshake
- `in_data`  in  K  operand word
- `out_valid` / `out_ready`  out / in  1  result stream handshake
- `out_data`  out  K  result word
- `out_last`  out  1  marks result word N-1
- `wr_ena`  out  3  one-hot RAM write enable: bit0 x, bit1 y, bit2 m
- `wr_addr`  out  ADDR_W  RAM word address
- `wr_x`, `wr_y`, `wr_m`  out  K  each driven with the registered operand word
- `wr_m1`  out  K  always driven from internal `m1_q`
- `task_req`  out  1  multiplication request
- `task_grant`  in  1  datapath accepted request
- `task_end`  in  1  result word valid on `task_res`
- `task_res`  in  K  result word

## Operation
- States: IDLE → LOAD_M1 → LOAD_X → LOAD_Y → LOAD_M → REQ → WAIT → CAPT → DRAIN → IDLE.
- Stream order is m1 (1 word), then x[0..N-1], y[0..N-1], m[0..N-1]. Word 0 is least significant.
- LOAD_M1: the accepted word goes to `m1_q` only; no RAM write.
- Other LOAD states: each accepted word produces exactly one write in the next cycle.
  - `wr_ena` carries one bit; `wr_addr` equals the word index.
  - The word-index counter wraps N-1 → 0 on the state change.
- `wr_m1` equals `m1_q` on every write, so the datapath's m1 register always latches the current value.
- `in_ready` is high only in LOAD states. No word is accepted outside them.
- REQ: `task_req` is held high until `task_grant` is sampled high, then goes low. Next state is WAIT.
- WAIT: the first cycle `task_end` is high captures `task_res` as word 0. Next state is CAPT.
- CAPT: words 1..N-1 are captured on consecutive cycles while `task_end` is high.
  - If `task_end` drops before word N-1 is captured: set `err`, discard the job, return to IDLE. `done` is not pulsed.
- `task_end` or `task_grant` outside WAIT/CAPT/REQ is ignored.
- DRAIN: results are presented in order 0..N-1.
  - `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
  - After the handshake on word N-1: `done` pulses and the state returns to IDLE.
- `start` while `busy` is ignored.

## Timing
- Reset values: `busy`, `err`, `done`, `in_ready`, `out_valid`, `out_last`, `task_req`, `wr_ena` = 0. `wr_addr`, `wr_x/y/m/m1`, `out_data`, `m1_q` = 0.
- Reset mid-job: the job is aborted immediately and the buffer contents are don't-care.
- All outputs are registered.
- Accepted `start` at edge t: `busy` = 1 and `in_ready` = 1 from cycle t+1.
- Word accepted at edge t: `wr_ena`/`wr_addr`/data are valid in cycle t+1 only.
- Last m word accepted at edge t: `task_req` = 1 from cycle t+2.
- Grant sampled at edge g: `task_req` = 0 from cycle g+1.
- Capture of word N-1 at edge c: `out_valid` = 1 from cycle c+1.
- Back-to-back output handshakes sustain 1 word/cycle.
- `done` is high in the cycle after the final handshake. `busy` = 0 in that same cycle.
- Minimum job with no stalls, measured from `start` to `done`: 1 + (3N+1) + 2 + grant/compute latency + N + N + 1 cycles.

## Configuration
- `IDDMM_SEQ_REUSE_M_EN` defined:
  - `keep_m` = 1 at `start` skips LOAD_M1 and LOAD_M. The stream is x then y; `m1_q` and the RAM m contents are reused.
  - LOAD_Y then proceeds directly to REQ.
- `IDDMM_SEQ_REUSE_M_EN` undefined:
  - The `keep_m` port is present but ignored.
  - Every job streams 3N+1 words.

## Test plan
- Reset, then K=128, N=4, stream m1=0x5, x=1..4, y=5..8, m=9..12:
  - Exactly 12 one-hot writes with addresses 0..3 per RAM.
  - `wr_m1` = 0x5 on each write.
  - `task_req` rises 2 cycles after the last accept.
- Grant after 7 cycles, `task_end` for 4 cycles with `task_res` = 0xA,0xB,0xC,0xD, `out_ready` tied 1:
  - `out_data` = A,B,C,D on 4 consecutive cycles, `out_last` on D.
  - `done` pulses once.
- Same job with `out_ready` toggling 1,0,0,1…:
  - No word lost or duplicated.
  - `out_data` stable during stalls.
- `task_end` drops after 2 words:
  - `err` = 1, return to IDLE, no `out_valid`, no `done`.
  - Next `start` clears `err`.
- `start` pulsed during LOAD_X, and `rst_n` asserted during CAPT:
  - The mid-job `start` is ignored.
  - Reset forces all outputs to their reset values within the same cycle.
- With `IDDMM_SEQ_REUSE_M_EN`, second job with `keep_m` = 1 and 8 words:
  - Only x/y writes occur.
  - `wr_m1` keeps 0x5.
  - `task_req` follows the last y write.

Source files
------------

// File: rtl/iddmm_seq.sv
// iddmm_seq: job sequencer in front of one iddmm_top Montgomery multiplier.
// Loads operands into the RAMs, runs the req/grant handshake and buffers results.
// Ports: clk, rst_n, start, keep_m, busy, err, done,
//   in_valid/in_ready/in_data (operand stream m1, x, y, m),
//   out_valid/out_ready/out_data/out_last (result stream),
//   wr_ena/wr_addr/wr_x/wr_y/wr_m/wr_m1 (RAM writes),
//   task_req/task_grant/task_end/task_res (datapath handshake).
// Optional macro IDDMM_SEQ_REUSE_M_EN: keep_m=1 at start reuses m1 and m.
module iddmm_seq #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              keep_m,
  output logic              busy,
  output logic              err,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_data,
  output logic              out_last,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_grant,
  input  logic              task_end,
  input  logic [K-1:0]      task_res
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_M1,
    S_LOAD_X,
    S_LOAD_Y,
    S_LOAD_M,
    S_REQ,
    S_WAIT,
    S_CAPT,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [K-1:0]      m1_q;
  logic [K-1:0]      wr_data;
  logic [K-1:0]      res_buf [N];
  logic              acc;
  logic              cap;

  assign acc   = in_valid & in_ready;
  assign cap   = task_end & ((state == S_WAIT) | (state == S_CAPT));
  assign wr_x  = wr_data;
  assign wr_y  = wr_data;
  assign wr_m  = wr_data;
  assign wr_m1 = m1_q;

`ifdef IDDMM_SEQ_REUSE_M_EN
  logic keep_q;
`else
  logic unused_keep;
  assign unused_keep = keep_m;
`endif

  // Result buffer holds no reset: its contents are dead outside a job.
  always_ff @(posedge clk) begin
    if (cap) res_buf[idx] <= task_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      m1_q      <= '0;
      wr_data   <= '0;
      wr_ena    <= '0;
      wr_addr   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      task_req  <= 1'b0;
`ifdef IDDMM_SEQ_REUSE_M_EN
      keep_q    <= 1'b0;
`endif
    end else begin
      wr_ena <= '0;
      done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            in_ready <= 1'b1;
            err      <= 1'b0;
            idx      <= '0;
`ifdef IDDMM_SEQ_REUSE_M_EN
            keep_q   <= keep_m;
            state    <= keep_m ? S_LOAD_X : S_LOAD_M1;
`else
            state    <= S_LOAD_M1;
`endif
          end
        end
        S_LOAD_M1: begin
          if (acc) begin
            m1_q  <= in_data;
            state <= S_LOAD_X;
          end
        end
        S_LOAD_X, S_LOAD_Y, S_LOAD_M: begin
          if (acc) begin
            wr_addr <= idx;
            wr_data <= in_data;
            unique case (1'b1)
              state == S_LOAD_X: wr_ena <= 3'b001;
              state == S_LOAD_Y: wr_ena <= 3'b010;
              default:           wr_ena <= 3'b100;
            endcase
            if (idx == LAST) begin
              idx <= '0;
              unique case (1'b1)
                state == S_LOAD_X: state <= S_LOAD_Y;
                state == S_LOAD_Y: begin
`ifdef IDDMM_SEQ_REUSE_M_EN
                  if (keep_q) begin
                    state    <= S_REQ;
                    in_ready <= 1'b0;
                  end else begin
                    state    <= S_LOAD_M;
                  end
`else
                  state <= S_LOAD_M;
`endif
                end
                default: begin
                  state    <= S_REQ;
                  in_ready <= 1'b0;
                end
              endcase
            end else begin
              idx <= idx + ONE;
            end
          end
        end
        S_REQ: begin
          // Request rises one cycle after entry; grant only counts once it is up.
          if (!task_req) begin
            task_req <= 1'b1;
          end else if (task_grant) begin
            task_req <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (task_end) begin
            idx   <= ONE;
            state <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (task_end) begin
            if (idx == LAST) begin
              idx       <= '0;
              state     <= S_DRAIN;
              out_valid <= 1'b1;
              out_data  <= res_buf[0];
              out_last  <= 1'b0;
            end else begin
              idx <= idx + ONE;
            end
          end else begin
            // Result burst broke up: the job is lost.
            err   <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              idx       <= '0;
              state     <= S_IDLE;
            end else begin
              idx      <= idx + ONE;
              out_data <= res_buf[idx + ONE];
              out_last <= ((idx + ONE) == LAST);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
